// File: rtl/video_timing_pkg.sv
// Default raster timing for the two vertical modes plus helpers that derive
// line/frame totals and sync window bounds from the porch/sync widths.
package video_timing_pkg;

    // Horizontal timing, shared by both modes
    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam bit          DEF_H_POL     = 1'b0;

    // Mode 0: 640x480
    localparam int unsigned DEF_V0_ACTIVE = 480;
    localparam int unsigned DEF_V0_FP     = 10;
    localparam int unsigned DEF_V0_SYNC   = 2;
    localparam int unsigned DEF_V0_BP     = 33;
    localparam bit          DEF_V0_POL    = 1'b0;

    // Mode 1: 640x400
    localparam int unsigned DEF_V1_ACTIVE = 400;
    localparam int unsigned DEF_V1_FP     = 12;
    localparam int unsigned DEF_V1_SYNC   = 2;
    localparam int unsigned DEF_V1_BP     = 35;
    localparam bit          DEF_V1_POL    = 1'b1;

    // Derived bounds of one axis; sync is asserted for sync_start <= pos < sync_end
    typedef struct packed {
        logic [31:0] total;
        logic [31:0] sync_start;
        logic [31:0] sync_end;
    } axis_bounds_t;

    function automatic axis_bounds_t axis_bounds(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        axis_bounds_t b;
        b.total      = active + fp + sync + bp;
        b.sync_start = active + fp;
        b.sync_end   = active + fp + sync;
        return b;
    endfunction

    function automatic logic in_window(input logic [31:0] pos,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// Wrapping position counter with a run-time maximum. Also exposes its next
// value so the parent can register sync outputs aligned with the count.
module video_axis_counter #(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: advance when enabled, wrapping to zero after max_i
    always_comb begin
        wrap_o  = en_i && (count_q == max_i);
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == max_i) ? '0 : count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised VGA raster timing generator with a pixel-clock divider, two
// vertical modes switched only at frame wrap, line/frame strobes and a frame
// counter. Sync outputs are registered from next counter values so they line
// up with hpos/vpos.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_W       = 10,
    parameter int unsigned V_W       = 10,
    parameter int unsigned FRAME_W   = 8,
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter bit          H_POL     = DEF_H_POL,
    parameter int unsigned V0_ACTIVE = DEF_V0_ACTIVE,
    parameter int unsigned V0_FP     = DEF_V0_FP,
    parameter int unsigned V0_SYNC   = DEF_V0_SYNC,
    parameter int unsigned V0_BP     = DEF_V0_BP,
    parameter bit          V0_POL    = DEF_V0_POL,
    parameter int unsigned V1_ACTIVE = DEF_V1_ACTIVE,
    parameter int unsigned V1_FP     = DEF_V1_FP,
    parameter int unsigned V1_SYNC   = DEF_V1_SYNC,
    parameter int unsigned V1_BP     = DEF_V1_BP,
    parameter bit          V1_POL    = DEF_V1_POL
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mode_sel_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               display_on_o,
    output logic [H_W-1:0]     hpos_o,
    output logic [V_W-1:0]     vpos_o,
    output logic               pix_en_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic [FRAME_W-1:0] frame_count_o,
    output logic               mode_active_o
);

    localparam axis_bounds_t HB  = axis_bounds(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam axis_bounds_t V0B = axis_bounds(V0_ACTIVE, V0_FP, V0_SYNC, V0_BP);
    localparam axis_bounds_t V1B = axis_bounds(V1_ACTIVE, V1_FP, V1_SYNC, V1_BP);

    localparam logic [H_W-1:0] H_MAX  = H_W'(HB.total - 32'd1);
    localparam logic [V_W-1:0] V0_MAX = V_W'(V0B.total - 32'd1);
    localparam logic [V_W-1:0] V1_MAX = V_W'(V1B.total - 32'd1);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DCNT_MAX = DIV_W'(CLK_DIV - 1);

    logic               run_q, run_d;
    logic [DIV_W-1:0]   dcnt_q, dcnt_d;
    logic               mode_q, mode_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;

    logic               adv;
    logic [H_W-1:0]     hpos, h_next;
    logic [V_W-1:0]     vpos, v_next;
    logic [V_W-1:0]     v_max;
    logic               h_wrap, frame_wrap;
    logic               v_pol;
    logic [31:0]        v_active;

    // Pixel counters step on the last clk of each divided pixel period
    assign adv   = run_q && (dcnt_q == DCNT_MAX);
    assign v_max = mode_q ? V1_MAX : V0_MAX;

    video_axis_counter #(
        .W (H_W)
    ) u_hcnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (adv),
        .max_i        (H_MAX),
        .count_o      (hpos),
        .count_next_o (h_next),
        .wrap_o       (h_wrap)
    );

    video_axis_counter #(
        .W (V_W)
    ) u_vcnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (h_wrap),
        .max_i        (v_max),
        .count_o      (vpos),
        .count_next_o (v_next),
        .wrap_o       (frame_wrap)
    );

    // Next-state: divider, mode latch at run start / frame wrap, frame count, syncs
    always_comb begin
        run_d   = 1'b1;
        dcnt_d  = dcnt_q;
        if (run_q) begin
            dcnt_d = (dcnt_q == DCNT_MAX) ? '0 : dcnt_q + 1'b1;
        end
        mode_d  = (!run_q || frame_wrap) ? mode_sel_i : mode_q;
        frame_d = frame_wrap ? frame_q + 1'b1 : frame_q;
        hsync_d = in_window(32'(h_next), HB.sync_start, HB.sync_end) ? H_POL : ~H_POL;
        // Use the incoming mode so a polarity change lands on the wrap edge
        v_pol   = mode_d ? V1_POL : V0_POL;
        if (mode_d) begin
            vsync_d = in_window(32'(v_next), V1B.sync_start, V1B.sync_end) ? v_pol : ~v_pol;
        end else begin
            vsync_d = in_window(32'(v_next), V0B.sync_start, V0B.sync_end) ? v_pol : ~v_pol;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q   <= 1'b0;
            dcnt_q  <= '0;
            mode_q  <= 1'b0;
            frame_q <= '0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V0_POL;
        end else begin
            run_q   <= run_d;
            dcnt_q  <= dcnt_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // Strobes and visible-area flag, decoded from registers only
    always_comb begin
        v_active      = mode_q ? V1_ACTIVE : V0_ACTIVE;
        pix_en_o      = run_q && (dcnt_q == '0);
        line_start_o  = pix_en_o && (hpos == '0);
        frame_start_o = line_start_o && (vpos == '0);
        display_on_o  = (32'(hpos) < H_ACTIVE) && (32'(vpos) < v_active);
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign hpos_o        = hpos;
    assign vpos_o        = vpos;
    assign frame_count_o = frame_q;
    assign mode_active_o = mode_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance checked against a
// table of raster positions, and two shrunken-timing instances (divider 1 and
// 2) checked every cycle against an arithmetic frame model under random mode
// requests, plus directed frame-period and asynchronous-reset sequences.
module tb_video_timing_gen;

    // Shrunken timing for the fast instances
    localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int S_V0A = 6, S_V0FP = 1, S_V0S = 2, S_V0BP = 1;
    localparam int S_V1A = 4, S_V1FP = 2, S_V1S = 1, S_V1BP = 2;
    localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT0 = S_V0A + S_V0FP + S_V0S + S_V0BP;
    localparam int S_VT1 = S_V1A + S_V1FP + S_V1S + S_V1BP;

    typedef struct packed {
        logic       hs, vs, de, pe, ls, fs, ma;
        logic [1:0] fc;
        logic [3:0] vp, hp;
    } obs_t;

    typedef struct packed {
        logic [9:0] hp, vp;
        logic [7:0] fc;
        logic       hs, vs, de, pe, ls, fs, ma;
    } dobs_t;

    typedef struct {
        bit run;
        int elapsed;  // clks since start of current frame
        bit mode;
        int fcount;
    } mstate_t;

    typedef struct {
        int cyc;
        int hp;
        int vp;
        bit hs;
        bit de;
        bit ls;
        bit fs;
    } dvec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic msel;

    logic       d_hs, d_vs, d_de, d_pe, d_ls, d_fs, d_ma;
    logic [9:0] d_hp, d_vp;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_de, s_pe, s_ls, s_fs, s_ma;
    logic [3:0] s_hp, s_vp;
    logic [1:0] s_fc;
    logic       v_hs, v_vs, v_de, v_pe, v_ls, v_fs, v_ma;
    logic [3:0] v_hp, v_vp;
    logic [1:0] v_fc;

    obs_t  sm_obs, dv_obs;
    dobs_t def_obs;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;
    int ti      = 0;
    mstate_t sm_s, dv_s;
    dvec_t tab[11];

    always #5 clk = ~clk;

    video_timing_gen u_def (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mode_sel_i    (1'b0),
        .hsync_o       (d_hs),
        .vsync_o       (d_vs),
        .display_on_o  (d_de),
        .hpos_o        (d_hp),
        .vpos_o        (d_vp),
        .pix_en_o      (d_pe),
        .line_start_o  (d_ls),
        .frame_start_o (d_fs),
        .frame_count_o (d_fc),
        .mode_active_o (d_ma)
    );

    video_timing_gen #(
        .H_W (4), .V_W (4), .FRAME_W (2), .CLK_DIV (1),
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP), .H_POL (1'b0),
        .V0_ACTIVE (S_V0A), .V0_FP (S_V0FP), .V0_SYNC (S_V0S), .V0_BP (S_V0BP), .V0_POL (1'b0),
        .V1_ACTIVE (S_V1A), .V1_FP (S_V1FP), .V1_SYNC (S_V1S), .V1_BP (S_V1BP), .V1_POL (1'b1)
    ) u_sm (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mode_sel_i    (msel),
        .hsync_o       (s_hs),
        .vsync_o       (s_vs),
        .display_on_o  (s_de),
        .hpos_o        (s_hp),
        .vpos_o        (s_vp),
        .pix_en_o      (s_pe),
        .line_start_o  (s_ls),
        .frame_start_o (s_fs),
        .frame_count_o (s_fc),
        .mode_active_o (s_ma)
    );

    video_timing_gen #(
        .H_W (4), .V_W (4), .FRAME_W (2), .CLK_DIV (2),
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP), .H_POL (1'b1),
        .V0_ACTIVE (S_V0A), .V0_FP (S_V0FP), .V0_SYNC (S_V0S), .V0_BP (S_V0BP), .V0_POL (1'b0),
        .V1_ACTIVE (S_V1A), .V1_FP (S_V1FP), .V1_SYNC (S_V1S), .V1_BP (S_V1BP), .V1_POL (1'b1)
    ) u_dv (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mode_sel_i    (msel),
        .hsync_o       (v_hs),
        .vsync_o       (v_vs),
        .display_on_o  (v_de),
        .hpos_o        (v_hp),
        .vpos_o        (v_vp),
        .pix_en_o      (v_pe),
        .line_start_o  (v_ls),
        .frame_start_o (v_fs),
        .frame_count_o (v_fc),
        .mode_active_o (v_ma)
    );

    assign sm_obs  = {s_hs, s_vs, s_de, s_pe, s_ls, s_fs, s_ma, s_fc, s_vp, s_hp};
    assign dv_obs  = {v_hs, v_vs, v_de, v_pe, v_ls, v_fs, v_ma, v_fc, v_vp, v_hp};
    assign def_obs = {d_hp, d_vp, d_fc, d_hs, d_vs, d_de, d_pe, d_ls, d_fs, d_ma};

    function automatic mstate_t mreset();
        mstate_t s;
        s.run = 1'b0; s.elapsed = 0; s.mode = 1'b0; s.fcount = 0;
        return s;
    endfunction

    // One clk edge of the frame model: frames are div*HT*VT(mode) clks long
    function automatic mstate_t mstep(mstate_t s, int div, bit sel);
        mstate_t n = s;
        if (!s.run) begin
            n.run = 1'b1; n.mode = sel; n.elapsed = 0;
        end else begin
            n.elapsed = s.elapsed + 1;
            if (n.elapsed == div * S_HT * (s.mode ? S_VT1 : S_VT0)) begin
                n.elapsed = 0; n.mode = sel; n.fcount = s.fcount + 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t mexp(mstate_t s, int div, bit hpol);
        obs_t o;
        int pix, hp, vp;
        bit pe;
        pix = s.run ? s.elapsed / div : 0;
        pe  = s.run && (s.elapsed % div == 0);
        hp  = pix % S_HT;
        vp  = pix / S_HT;
        o.hp = 4'(hp);
        o.vp = 4'(vp);
        o.pe = pe;
        o.ls = pe && hp == 0;
        o.fs = pe && hp == 0 && vp == 0;
        o.hs = (hp >= S_HA + S_HFP && hp < S_HA + S_HFP + S_HS) ? hpol : !hpol;
        if (s.mode) o.vs = (vp >= S_V1A + S_V1FP && vp < S_V1A + S_V1FP + S_V1S) ? 1'b1 : 1'b0;
        else        o.vs = (vp >= S_V0A + S_V0FP && vp < S_V0A + S_V0FP + S_V0S) ? 1'b0 : 1'b1;
        o.de = hp < S_HA && vp < (s.mode ? S_V1A : S_V0A);
        o.ma = s.mode;
        o.fc = 2'(s.fcount % 4);
        return o;
    endfunction

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_def(input string name, input dobs_t act, input dobs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        dobs_t e;
        e = '{hp: 10'd0, vp: 10'd0, fc: 8'd0, hs: 1'b1, vs: 1'b1, de: 1'b1,
              pe: 1'b0, ls: 1'b0, fs: 1'b0, ma: 1'b0};
        chk_def({name, "_def"}, def_obs, e);
        chk_obs({name, "_sm"}, sm_obs, mexp(mreset(), 1, 1'b0));
        chk_obs({name, "_dv"}, dv_obs, mexp(mreset(), 2, 1'b1));
    endtask

    // One clk: advance models on the edge, compare everything on the falling edge
    task automatic step();
        dobs_t e;
        @(posedge clk);
        cyc++;
        sm_s = mstep(sm_s, 1, msel);
        dv_s = mstep(dv_s, 2, msel);
        @(negedge clk);
        chk_obs("model_sm", sm_obs, mexp(sm_s, 1, 1'b0));
        chk_obs("model_dv", dv_obs, mexp(dv_s, 2, 1'b1));
        if (ti < 11 && tab[ti].cyc == cyc) begin
            e.hp = 10'(tab[ti].hp);
            e.vp = 10'(tab[ti].vp);
            e.fc = 8'd0;
            e.hs = tab[ti].hs;
            e.vs = 1'b1;
            e.de = tab[ti].de;
            e.pe = 1'b1;
            e.ls = tab[ti].ls;
            e.fs = tab[ti].fs;
            e.ma = 1'b0;
            chk_def($sformatf("table_%0d", ti), def_obs, e);
            ti++;
        end
    endtask

    initial begin
        int n;
        // Default 640x480 raster, indexed by run cycle since reset release
        tab[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
        tab[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[2]  = '{639,  639, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[3]  = '{640,  640, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[4]  = '{655,  655, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[5]  = '{656,  656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[6]  = '{751,  751, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[7]  = '{752,  752, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[8]  = '{799,  799, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[10] = '{1456, 656, 1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        msel  = 1'b0;
        sm_s  = mreset();
        dv_s  = mreset();
        repeat (2) @(negedge clk);
        chk_reset("reset_init");
        rst_n = 1'b1;

        // Random mode requests, then a held request from cycle 1500 onward
        for (int i = 0; i < 2000; i++) begin
            msel = (cyc >= 1500) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        chk_int("table_entries_reached", ti, 11);

        // Mode 1 frame periods, measured between frame_start pulses
        n = 0;
        while (!s_fs && n < 200) begin step(); n++; end
        n = 0;
        do begin step(); n++; end while (!s_fs && n < 300);
        chk_int("frame_period_sm", n, S_HT * S_VT1);
        n = 0;
        while (!v_fs && n < 400) begin step(); n++; end
        n = 0;
        do begin step(); n++; end while (!v_fs && n < 600);
        chk_int("frame_period_dv", n, 2 * S_HT * S_VT1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        sm_s = mreset();
        dv_s = mreset();
        @(negedge clk);
        chk_reset("reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            msel = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
